clk_divider: RTL

Programmable integer clock divider that produces the divided clock consumed by the downstream inverter stage, which builds the inverted copy used by neighbouring serial logic. Runs entirely in the reference clock domain. Division ratio and enable come from the configuration register file. A bypass path forwards the reference clock when division is disabled or not meaningful.

---
 rtl/clk_divider.sv | 66 ++++++
 1 files changed

// File: rtl/clk_divider.sv
// clk_divider: integer divider of CLK (ratio 2..2^RATIO_WIDTH-1); odd ratios only with CLK_DIV_ODD_EN defined.
// div_clk/div_tick rise on the first enabled edge; free-running, no backpressure; bypass forwards CLK.
module clk_divider #(
   parameter int RATIO_WIDTH = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   clk_div_en,
   input  logic [RATIO_WIDTH-1:0] div_ratio,
   output logic                   div_clk,
   output logic                   div_tick
);

   localparam logic [RATIO_WIDTH-1:0] ONE = RATIO_WIDTH'(1);
   localparam logic [RATIO_WIDTH-1:0] TWO = RATIO_WIDTH'(2);

   logic [RATIO_WIDTH-1:0] cnt;
   logic [RATIO_WIDTH-1:0] ratio_q;
   logic [RATIO_WIDTH-1:0] ratio_raw;
   logic [RATIO_WIDTH-1:0] neff;
   logic [RATIO_WIDTH-1:0] half;
   logic                   div_clk_q;
   logic                   div_tick_q;
   logic                   bypass_q;
   logic                   bypass_n;

   // A new ratio is only honoured at a period boundary, so no runt pulses appear.
   always_comb begin
      ratio_raw = (cnt == '0) ? div_ratio : ratio_q;
`ifdef CLK_DIV_ODD_EN
      neff      = ratio_raw;
`else
      neff      = ratio_raw & ~ONE;
`endif
      half      = neff >> 1;
      bypass_n  = !clk_div_en || (neff < TWO);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt        <= '0;
         ratio_q    <= '0;
         div_clk_q  <= 1'b0;
         div_tick_q <= 1'b0;
         bypass_q   <= 1'b1;
      end else begin
         if (cnt == '0)
            ratio_q <= div_ratio;
         if (bypass_n) begin
            cnt        <= '0;
            div_clk_q  <= 1'b0;
            div_tick_q <= 1'b0;
            bypass_q   <= 1'b1;
         end else begin
            bypass_q   <= 1'b0;
            div_clk_q  <= (cnt < half);
            div_tick_q <= (cnt == '0);
            cnt        <= (cnt == neff - ONE) ? '0 : cnt + ONE;
         end
      end
   end

   assign div_clk  = bypass_q ? CLK : div_clk_q;
   assign div_tick = div_tick_q;

endmodule
